cv32e40p_regfile_fault_tracker: RTL and testbench

// Per-location fault bookkeeping and main->spare remap controller for the ECC-protected, duplicated register file.

---
 rtl/cv32e40p_ft_pkg.sv | 16 +
 rtl/cv32e40p_regfile_fault_tracker_if.sv | 18 +
 rtl/cv32e40p_ft_leaky_counter.sv | 40 ++++
 rtl/cv32e40p_regfile_fault_tracker.sv | 184 ++++++++++++++++++
 tb/tb_cv32e40p_regfile_fault_tracker.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and constants for the register-file fault tracker.
//   mig_state_e : migration FSM states
//   SEC_W/DED_W : fault-counter increments for corrected / detected-uncorrectable reads
package cv32e40p_ft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    COPY   = 2'd2,
    COMMIT = 2'd3
  } mig_state_e;

  localparam int unsigned SEC_W = 1;
  localparam int unsigned DED_W = 4;

endpackage

// File: rtl/cv32e40p_regfile_fault_tracker_if.sv
// Migration handshake between the fault tracker and the FT regfile wrapper / core.
//   mig_req      : tracker asks the core to stall
//   mig_gnt      : core stalled, held until mig_req drops
//   mig_addr     : location being migrated
//   mig_we_spare : spare-bank write strobe for the corrected word
interface cv32e40p_regfile_fault_tracker_if #(
  parameter int unsigned ADDR_WIDTH = 6
) ();

  logic                  mig_req;
  logic                  mig_gnt;
  logic [ADDR_WIDTH-1:0] mig_addr;
  logic                  mig_we_spare;

  modport master (output mig_req, output mig_addr, output mig_we_spare, input mig_gnt);
  modport slave  (input  mig_req, input  mig_addr, input  mig_we_spare, output mig_gnt);

endinterface

// File: rtl/cv32e40p_ft_leaky_counter.sv
// Saturating leaky fault counter for one register location.
//   inc_i     : weighted increment this cycle
//   dec_i     : decay tick (only applied when count is non-zero)
//   freeze_i  : location pending/damaged, counter holds
//   thr_hit_c : next count reaches THRESHOLD (combinational)
module cv32e40p_ft_leaky_counter #(
  parameter int unsigned CNT_WIDTH = 5,
  parameter int unsigned THRESHOLD = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_WIDTH-1:0] inc_i,
  input  logic                 dec_i,
  input  logic                 freeze_i,
  output logic                 thr_hit_c
);

  localparam int unsigned SUM_W = CNT_WIDTH + 1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]     sum_c;

  // One extra bit of headroom so inc on top of a high count still clamps cleanly.
  always_comb begin
    cnt_d = cnt_q;
    sum_c = '0;
    if (!freeze_i) begin
      sum_c = SUM_W'(cnt_q) + SUM_W'(inc_i) - SUM_W'(dec_i && (cnt_q != '0));
      if (sum_c >= SUM_W'(THRESHOLD)) cnt_d = CNT_WIDTH'(THRESHOLD);
      else                            cnt_d = sum_c[CNT_WIDTH-1:0];
    end
    thr_hit_c = !freeze_i && (cnt_d == CNT_WIDTH'(THRESHOLD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cv32e40p_regfile_fault_tracker.sv
// Per-location fault bookkeeping and main->spare remap controller for the
// ECC-protected duplicated register file.
//   rd_*           : read-port addresses, valids and SEC/DED flags
//   wr_*           : core write addresses/enables, gated per bank on outputs
//   damaged_init_i : damaged map loaded while in reset
//   rd_sel_spare_o : per read port, read from spare bank
//   mig_if         : migration handshake (master side)
//   damaged_o      : current damaged map, perf_we_o pulses when it gains a bit
module cv32e40p_regfile_fault_tracker
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned NUM_RPORTS   = 3,
  parameter int unsigned NUM_WPORTS   = 2,
  parameter int unsigned CNT_WIDTH    = 5,
  parameter int unsigned THRESHOLD    = 31,
  parameter int unsigned DED_WEIGHT   = DED_W,
  parameter int unsigned DECAY_PERIOD = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [NUM_RPORTS-1:0]            rd_valid_i,
  input  logic [NUM_RPORTS-1:0]            rd_sec_i,
  input  logic [NUM_RPORTS-1:0]            rd_ded_i,
  input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WPORTS-1:0]            wr_en_i,
  input  logic [NUM_REGS-1:0]              damaged_init_i,
  output logic [NUM_RPORTS-1:0]            rd_sel_spare_o,
  output logic [NUM_WPORTS-1:0]            wr_en_main_o,
  output logic [NUM_WPORTS-1:0]            wr_en_spare_o,
  cv32e40p_regfile_fault_tracker_if.master mig_if,
  output logic [NUM_REGS-1:0]              damaged_o,
  output logic                             perf_we_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned PRE_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  mig_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] mig_addr_q, mig_addr_d, low_idx_c;
  logic                  mig_req_q, mig_req_d;
  logic                  mig_we_q, mig_we_d;
  logic                  perf_we_q, perf_we_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [NUM_REGS-1:0]   damaged_q, damaged_d;
  logic [NUM_REGS-1:0]   pend_hit_c;
  logic [CNT_WIDTH-1:0]  inc_c [NUM_REGS-1:1];
  logic                  tick_c;

  function automatic logic tracked(input logic [ADDR_WIDTH-1:0] a);
    return (a >> IDX_W) == '0;
  endfunction

  // Bank selects: damaged -> spare only, pending -> both, else main only.
  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    for (int p = 0; p < int'(NUM_RPORTS); p++) begin
      a = rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_sel_spare_o[p] = tracked(a) && damaged_q[a[IDX_W-1:0]];
    end
    for (int w = 0; w < int'(NUM_WPORTS); w++) begin
      a = wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH];
      wr_en_main_o[w]  = wr_en_i[w] && !(tracked(a) && damaged_q[a[IDX_W-1:0]]);
      wr_en_spare_o[w] = wr_en_i[w] && tracked(a) &&
                         (damaged_q[a[IDX_W-1:0]] || pending_q[a[IDX_W-1:0]]);
    end
  end

  // Per-location event weight: several ports on one address count once, DED dominates.
  always_comb begin
    logic sec_any, ded_any;
    sec_any = 1'b0;
    ded_any = 1'b0;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      sec_any = 1'b0;
      ded_any = 1'b0;
      for (int p = 0; p < int'(NUM_RPORTS); p++) begin
        if (rd_valid_i[p] && (rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i))) begin
          sec_any = sec_any | rd_sec_i[p];
          ded_any = ded_any | rd_ded_i[p];
        end
      end
      inc_c[i] = ded_any ? CNT_WIDTH'(DED_WEIGHT) :
                 sec_any ? CNT_WIDTH'(SEC_W)      : '0;
    end
  end

  // Free-running decay prescaler.
  if (DECAY_PERIOD == 0) begin : g_no_decay
    assign tick_c = 1'b0;
  end else begin : g_decay
    logic [PRE_W-1:0] pre_q, pre_d;
    always_comb begin
      tick_c = (pre_q == PRE_W'(DECAY_PERIOD - 1));
      pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre_q <= '0;
      else        pre_q <= pre_d;
    end
  end

  // x0 has no counter; damaged or pending locations are frozen.
  assign pend_hit_c[0] = 1'b0;
  for (genvar i = 1; i < int'(NUM_REGS); i++) begin : g_loc
    cv32e40p_ft_leaky_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .THRESHOLD (THRESHOLD)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (inc_c[i]),
      .dec_i     (tick_c),
      .freeze_i  (pending_q[i] | damaged_q[i]),
      .thr_hit_c (pend_hit_c[i])
    );
  end

  // Lowest pending index wins.
  always_comb begin
    low_idx_c = '0;
    for (int i = int'(NUM_REGS) - 1; i >= 1; i--) begin
      if (pending_q[i]) low_idx_c = ADDR_WIDTH'(i);
    end
  end

  // Migration FSM next state; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    mig_addr_d = mig_addr_q;
    pending_d  = pending_q | pend_hit_c;
    damaged_d  = damaged_q;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d    = REQ;
          mig_addr_d = low_idx_c;
        end
      end
      REQ:  if (mig_if.mig_gnt) state_d = COPY;
      COPY: begin
        state_d = COMMIT;
        pending_d[mig_addr_q[IDX_W-1:0]] = 1'b0;
        damaged_d[mig_addr_q[IDX_W-1:0]] = 1'b1;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mig_req_d = (state_d == REQ) || (state_d == COPY);
    mig_we_d  = (state_d == COPY);
    perf_we_d = (state_d == COMMIT);
  end

  // Damaged map keeps reloading from the init vector for as long as reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mig_addr_q <= '0;
      mig_req_q  <= 1'b0;
      mig_we_q   <= 1'b0;
      perf_we_q  <= 1'b0;
      pending_q  <= '0;
      damaged_q  <= damaged_init_i & ~NUM_REGS'(1);
    end else begin
      state_q    <= state_d;
      mig_addr_q <= mig_addr_d;
      mig_req_q  <= mig_req_d;
      mig_we_q   <= mig_we_d;
      perf_we_q  <= perf_we_d;
      pending_q  <= pending_d;
      damaged_q  <= damaged_d;
    end
  end

  assign mig_if.mig_req      = mig_req_q;
  assign mig_if.mig_addr     = mig_addr_q;
  assign mig_if.mig_we_spare = mig_we_q;
  assign damaged_o           = damaged_q;
  assign perf_we_o           = perf_we_q;

endmodule

// File: tb/tb_cv32e40p_regfile_fault_tracker.sv
// Bench for the fault tracker: dut0 has decay disabled and default threshold,
// dut1 uses THRESHOLD=4 / DECAY_PERIOD=16 for the leak behaviour.
// Expected migrations are queued by the stimulus and popped by a monitor on perf_we_o.
module tb_cv32e40p_regfile_fault_tracker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [17:0] rd_addr0, rd_addr1;
  logic [2:0]  rd_valid0, rd_sec0, rd_ded0, rd_valid1, rd_sec1, rd_ded1;
  logic [11:0] wr_addr0, wr_addr1;
  logic [1:0]  wr_en0, wr_en1;
  logic [31:0] dinit0, dinit1;
  logic [2:0]  sel0, sel1;
  logic [1:0]  wm0, ws0, wm1, ws1;
  logic [31:0] dmg0, dmg1;
  logic        pw0, pw1;

  cv32e40p_regfile_fault_tracker_if #(.ADDR_WIDTH(6)) mif0 ();
  cv32e40p_regfile_fault_tracker_if #(.ADDR_WIDTH(6)) mif1 ();

  cv32e40p_regfile_fault_tracker #(.DECAY_PERIOD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr0), .rd_valid_i(rd_valid0),
    .rd_sec_i(rd_sec0), .rd_ded_i(rd_ded0), .wr_addr_i(wr_addr0), .wr_en_i(wr_en0),
    .damaged_init_i(dinit0), .rd_sel_spare_o(sel0), .wr_en_main_o(wm0),
    .wr_en_spare_o(ws0), .mig_if(mif0.master), .damaged_o(dmg0), .perf_we_o(pw0));

  cv32e40p_regfile_fault_tracker #(.THRESHOLD(4), .DECAY_PERIOD(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr1), .rd_valid_i(rd_valid1),
    .rd_sec_i(rd_sec1), .rd_ded_i(rd_ded1), .wr_addr_i(wr_addr1), .wr_en_i(wr_en1),
    .damaged_init_i(dinit1), .rd_sel_spare_o(sel1), .wr_en_main_o(wm1),
    .wr_en_spare_o(ws1), .mig_if(mif1.master), .damaged_o(dmg1), .perf_we_o(pw1));

  int total = 0;
  int bad   = 0;
  int exp0[$];
  int exp1[$];
  int e0, e1;
  int cyc = 0;
  bit gnt_en0 = 1'b0;
  bit gnt_en1 = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Cycles since reset release; equals dut1's prescaler value during the current cycle.
  initial forever begin
    @(posedge clk);
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  // Grant responder and commit monitor.
  initial forever begin
    @(negedge clk);
    mif0.mig_gnt = mif0.mig_req & gnt_en0;
    mif1.mig_gnt = mif1.mig_req & gnt_en1;
    if (rst_n && pw0) begin
      if (exp0.size() == 0) begin
        total++; bad++;
        $display("FAIL commit0_unexpected got=%0d want=none", mif0.mig_addr);
      end else begin
        e0 = exp0.pop_front();
        chk("commit0_addr", 32'(mif0.mig_addr), 32'(e0));
        chk("commit0_dmg", 32'(dmg0[e0]), 32'd1);
      end
    end
    if (rst_n && pw1) begin
      if (exp1.size() == 0) begin
        total++; bad++;
        $display("FAIL commit1_unexpected got=%0d want=none", mif1.mig_addr);
      end else begin
        e1 = exp1.pop_front();
        chk("commit1_addr", 32'(mif1.mig_addr), 32'(e1));
        chk("commit1_dmg", 32'(dmg1[e1]), 32'd1);
      end
    end
  end

  task automatic rd0(input logic [2:0] v, input logic [2:0] ded,
                     input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2, input int n);
    rd_valid0 = v; rd_sec0 = v & ~ded; rd_ded0 = v & ded; rd_addr0 = {a2, a1, a0};
    repeat (n) @(negedge clk);
    rd_valid0 = '0; rd_sec0 = '0; rd_ded0 = '0;
  endtask

  task automatic rd1(input logic [5:0] a0, input int n);
    rd_valid1 = 3'b001; rd_sec1 = 3'b001; rd_ded1 = '0; rd_addr1 = {12'd0, a0};
    repeat (n) @(negedge clk);
    rd_valid1 = '0; rd_sec1 = '0;
  endtask

  task automatic wait_req0(input string name, input int budget);
    int k = 0;
    while (!mif0.mig_req && k < budget) begin @(negedge clk); k++; end
    chk(name, 32'(mif0.mig_req), 32'd1);
  endtask

  task automatic wait_req1(input string name, input int budget);
    int k = 0;
    while (!mif1.mig_req && k < budget) begin @(negedge clk); k++; end
    chk(name, 32'(mif1.mig_req), 32'd1);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp0.size() + exp1.size()) != 0 && k < budget) begin @(negedge clk); k++; end
    chk(name, 32'(exp0.size() + exp1.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr0 = '0; rd_valid0 = '0; rd_sec0 = '0; rd_ded0 = '0; wr_addr0 = '0; wr_en0 = '0;
    rd_addr1 = '0; rd_valid1 = '0; rd_sec1 = '0; rd_ded1 = '0; wr_addr1 = '0; wr_en1 = '0;
    dinit0 = 32'h0000_0101; dinit1 = '0;
    mif0.mig_gnt = 1'b0; mif1.mig_gnt = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_damaged", dmg0, 32'h0000_0100);
    chk("rst_req", 32'(mif0.mig_req), 32'd0);
    chk("rst_perf", 32'(pw0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bank selects from the reset-loaded map; address 40 aliases x8 but is untracked.
    rd_addr0 = {6'd0, 6'd40, 6'd8}; rd_valid0 = 3'b011;
    wr_addr0 = {6'd40, 6'd8}; wr_en0 = 2'b11;
    #1;
    chk("sel_init", 32'(sel0), 32'd1);
    chk("wr_main_init", 32'(wm0), 32'd2);
    chk("wr_spare_init", 32'(ws0), 32'd1);
    @(negedge clk);
    rd_valid0 = '0; wr_en0 = '0;

    // 31 SECs on x5.
    rd0(3'b001, 3'b000, 6'd5, 6'd0, 6'd0, 30);
    repeat (4) @(negedge clk);
    chk("x5_30_noreq", 32'(mif0.mig_req), 32'd0);
    rd0(3'b001, 3'b000, 6'd5, 6'd0, 6'd0, 1);
    wait_req0("x5_req", 5);
    chk("x5_addr", 32'(mif0.mig_addr), 32'd5);
    exp0.push_back(5);
    gnt_en0 = 1'b1;
    drain("x5_drain", 20);
    rd_addr0 = {6'd0, 6'd0, 6'd5}; #1;
    chk("x5_sel", 32'(sel0[0]), 32'd1);
    @(negedge clk);

    // DEDs on x9 via port B: 7*4=28 stays below, the 8th saturates at 31.
    gnt_en0 = 1'b0;
    rd0(3'b010, 3'b010, 6'd0, 6'd9, 6'd0, 7);
    repeat (4) @(negedge clk);
    chk("x9_7ded_noreq", 32'(mif0.mig_req), 32'd0);
    rd0(3'b010, 3'b010, 6'd0, 6'd9, 6'd0, 1);
    wait_req0("x9_req", 5);
    chk("x9_addr", 32'(mif0.mig_addr), 32'd9);
    exp0.push_back(9);
    gnt_en0 = 1'b1;
    drain("x9_drain", 20);

    // x3 on all three ports for 10 cycles counts 10, so 20 more single SECs stay at 30.
    gnt_en0 = 1'b0;
    rd0(3'b111, 3'b000, 6'd3, 6'd3, 6'd3, 10);
    rd0(3'b001, 3'b000, 6'd3, 6'd0, 6'd0, 20);
    repeat (4) @(negedge clk);
    chk("x3_30_noreq", 32'(mif0.mig_req), 32'd0);
    rd0(3'b001, 3'b000, 6'd3, 6'd0, 6'd0, 1);
    wait_req0("x3_req", 5);
    chk("x3_addr", 32'(mif0.mig_addr), 32'd3);
    exp0.push_back(3);
    gnt_en0 = 1'b1;
    drain("x3_drain", 20);

    // x4 and x6 pend together: 4 first, and pending writes go to both banks.
    gnt_en0 = 1'b0;
    rd0(3'b011, 3'b000, 6'd4, 6'd6, 6'd0, 31);
    wait_req0("x46_req", 5);
    chk("x46_first_addr", 32'(mif0.mig_addr), 32'd4);
    exp0.push_back(4);
    exp0.push_back(6);
    wr_addr0 = {6'd4, 6'd6}; wr_en0 = 2'b11; #1;
    chk("pend_wr_main", 32'(wm0), 32'd3);
    chk("pend_wr_spare", 32'(ws0), 32'd3);
    @(negedge clk);
    wr_en0 = '0;
    gnt_en0 = 1'b1;
    drain("x46_drain", 40);
    chk("damaged_all", dmg0, 32'h0000_0378);
    wr_en0 = 2'b11; #1;
    chk("dmg_wr_main", 32'(wm0), 32'd0);
    chk("dmg_wr_spare", 32'(ws0), 32'd3);
    @(negedge clk);
    wr_en0 = '0;

    // Reset while copying x10.
    gnt_en0 = 1'b0;
    rd0(3'b001, 3'b000, 6'd10, 6'd0, 6'd0, 31);
    wait_req0("x10_req", 5);
    gnt_en0 = 1'b1;
    begin
      int k = 0;
      while (!mif0.mig_we_spare && k < 10) begin @(negedge clk); k++; end
    end
    chk("x10_copy", 32'(mif0.mig_we_spare), 32'd1);
    dinit0 = 32'h0000_0401;
    rst_n = 1'b0; #1;
    chk("rstcopy_req", 32'(mif0.mig_req), 32'd0);
    chk("rstcopy_we", 32'(mif0.mig_we_spare), 32'd0);
    chk("rstcopy_dmg", dmg0, 32'h0000_0400);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("after_rst_noreq", 32'(mif0.mig_req), 32'd0);
    rd_addr0 = {6'd0, 6'd0, 6'd10}; #1;
    chk("x10_sel_after_rst", 32'(sel0[0]), 32'd1);
    rd_addr0 = {6'd0, 6'd0, 6'd5}; #1;
    chk("x5_sel_after_rst", 32'(sel0[0]), 32'd0);
    @(negedge clk);

    // x0 is never counted, SEC or DED.
    rd0(3'b111, 3'b101, 6'd0, 6'd0, 6'd0, 40);
    repeat (4) @(negedge clk);
    chk("x0_noreq", 32'(mif0.mig_req), 32'd0);

    // Decay on dut1 (threshold 4, tick every 16 cycles).
    rd1(6'd7, 3);
    repeat (64) @(negedge clk);
    while (cyc % 16 != 0) @(negedge clk);
    rd1(6'd7, 3);
    while (cyc % 16 != 15) @(negedge clk);
    rd1(6'd7, 1);
    repeat (3) @(negedge clk);
    chk("decay_noreq", 32'(mif1.mig_req), 32'd0);
    exp1.push_back(7);
    rd1(6'd7, 1);
    wait_req1("decay_req", 5);
    chk("decay_addr", 32'(mif1.mig_addr), 32'd7);
    drain("decay_drain", 20);

    chk("queues_empty", 32'(exp0.size() + exp1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
